// File: rtl/hit_judge_if.sv
// Signal bundle between the judge and its surroundings: player/shifter inputs and judgement outputs.
// The master drives the player and shifter inputs; the slave (the judge) drives the results.
interface hit_judge_if;
  logic        start;
  logic        finish;
  logic        red_button;
  logic        blue_button;
  logic        note_R_judge;
  logic        note_B_judge;
  logic [2:0]  offset;
  logic        delete;
  logic [1:0]  judge;
  logic        judge_vld;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic        done;

  modport master (
    output start, finish, red_button, blue_button, note_R_judge, note_B_judge, offset,
    input  delete, judge, judge_vld, score, combo, max_combo, done
  );

  modport slave (
    input  start, finish, red_button, blue_button, note_R_judge, note_B_judge, offset,
    output delete, judge, judge_vld, score, combo, max_combo, done
  );
endinterface

// File: rtl/hit_judge.sv
// Judges debounced red/blue presses against the note at the judge column, pulses delete on a hit,
// and keeps score, combo and max combo for the current song.
module hit_judge #(
  parameter int unsigned DB_W      = 17,
  parameter int unsigned DB_CYCLES = 50000,
  parameter logic [2:0]  PERF_LO   = 3'd2,
  parameter logic [2:0]  PERF_HI   = 3'd4,
  parameter logic [15:0] PERF_PTS  = 16'd3,
  parameter logic [15:0] GOOD_PTS  = 16'd1
) (
  input logic        clk,
  input logic        rst,
  hit_judge_if.slave bus
);

  localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

  localparam logic [1:0] JNone = 2'd0;
  localparam logic [1:0] JPerf = 2'd1;
  localparam logic [1:0] JGood = 2'd2;
  localparam logic [1:0] JMiss = 2'd3;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 is red, index 1 is blue
  // ---------------------------------------------------------------------------
  logic [1:0]      btn_raw;
  logic [1:0]      meta_q, sync_q;
  logic [1:0]      db_q, db_d, db_dly_q;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];
  logic [1:0]      press;
  logic            press_r, press_b;

  assign btn_raw = {bus.blue_button, bus.red_button};

  // The counter runs only while the synchronized level disagrees with the accepted level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          db_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q   <= btn_raw;
      sync_q   <= meta_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign press   = db_q & ~db_dly_q;
  assign press_r = press[0];
  assign press_b = press[1];

  // ---------------------------------------------------------------------------
  // Song FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   play;
  logic   done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StPlay;
      StPlay: begin
        if (bus.start) begin
          state_d = StPlay;
        end else if (bus.finish) begin
          state_d = StDone;
        end
      end
      StDone: if (bus.start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    play = (state_q == StPlay);
    done = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Note tracking and judging
  // ---------------------------------------------------------------------------
  logic note_r, note_b, note_now;
  logic note_r_prev_q, note_b_prev_q;
  logic fall;
  logic eff_r, eff_b, eff_note;
  logic any_press, hit_ok, perfect, judging;

  // Both colours high is illegal; red wins.
  assign note_r   = bus.note_R_judge;
  assign note_b   = bus.note_B_judge & ~bus.note_R_judge;
  assign note_now = note_r | note_b;
  assign fall     = (note_r_prev_q | note_b_prev_q) & ~note_now;

  // On the fall cycle the departing note is still hittable.
  assign eff_r    = note_r | (fall & note_r_prev_q);
  assign eff_b    = note_b | (fall & note_b_prev_q);
  assign eff_note = eff_r | eff_b;

  assign any_press = press_r | press_b;
  assign hit_ok    = (press_r ^ press_b) & ((press_r & eff_r) | (press_b & eff_b));
  assign perfect   = (bus.offset >= PERF_LO) && (bus.offset <= PERF_HI);
  assign judging   = play & ~bus.finish;

  logic        consumed_q, consumed_d;
  logic [1:0]  judge_q, judge_d;
  logic        vld_q, vld_d;
  logic        delete_q, delete_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [7:0]  max_q, max_d;

  logic [15:0] hit_pts;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic [7:0]  combo_inc;

  assign hit_pts   = perfect ? PERF_PTS : GOOD_PTS;
  assign score_sum = {1'b0, score_q} + {1'b0, hit_pts};
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign combo_inc = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;

  always_comb begin
    judge_d    = JNone;
    vld_d      = 1'b0;
    delete_d   = 1'b0;
    consumed_d = consumed_q;
    score_d    = score_q;
    combo_d    = combo_q;
    max_d      = max_q;
    if (bus.start) begin
      consumed_d = 1'b0;
      score_d    = '0;
      combo_d    = '0;
      max_d      = '0;
    end else if (judging) begin
      if (any_press && eff_note && !consumed_q) begin
        vld_d      = 1'b1;
        // A note judged on its fall cycle is already gone, so the next note starts fresh.
        consumed_d = ~fall;
        if (hit_ok) begin
          judge_d  = perfect ? JPerf : JGood;
          delete_d = 1'b1;
          score_d  = score_sat;
          combo_d  = combo_inc;
          if (combo_inc > max_q) max_d = combo_inc;
        end else begin
          judge_d = JMiss;
          combo_d = '0;
        end
      end else if (fall) begin
        consumed_d = 1'b0;
        if (!consumed_q) begin
          vld_d   = 1'b1;
          judge_d = JMiss;
          combo_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_r_prev_q <= 1'b0;
      note_b_prev_q <= 1'b0;
      consumed_q    <= 1'b0;
      judge_q       <= JNone;
      vld_q         <= 1'b0;
      delete_q      <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      max_q         <= '0;
    end else begin
      note_r_prev_q <= note_r;
      note_b_prev_q <= note_b;
      consumed_q    <= consumed_d;
      judge_q       <= judge_d;
      vld_q         <= vld_d;
      delete_q      <= delete_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_q         <= max_d;
    end
  end

  assign bus.delete    = delete_q;
  assign bus.judge     = judge_q;
  assign bus.judge_vld = vld_q;
  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.max_combo = max_q;
  assign bus.done      = done;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: expected strobes are queued when a press or fall is driven and
// checked by a monitor when judge_vld appears; stray strobes and leftover expectations fail.
module tb_hit_judge;
  localparam int unsigned DbCycles = 250;
  localparam int unsigned DbW      = 9;
  localparam int unsigned Hold     = DbCycles + 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hit_judge_if bus ();

  hit_judge #(
    .DB_W     (DbW),
    .DB_CYCLES(DbCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]  j;
    logic        del;
    logic [15:0] sc;
    logic [7:0]  co;
    logic [7:0]  mx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_score = 0;
  int   m_combo = 0;
  int   m_max   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_hit(input logic [2:0] off);
    bit perf;
    perf = (off >= 3'd2) && (off <= 3'd4);
    m_score = m_score + (perf ? 3 : 1);
    if (m_score > 65535) m_score = 65535;
    if (m_combo < 255) m_combo++;
    if (m_combo > m_max) m_max = m_combo;
    sb.push_back('{perf ? 2'd1 : 2'd2, 1'b1, 16'(m_score), 8'(m_combo), 8'(m_max)});
  endtask

  task automatic push_miss();
    m_combo = 0;
    sb.push_back('{2'd3, 1'b0, 16'(m_score), 8'(m_combo), 8'(m_max)});
  endtask

  task automatic model_clear();
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
  endtask

  task automatic press(input logic r, input logic b);
    bus.red_button  = r;
    bus.blue_button = b;
    cyc(Hold);
    bus.red_button  = 1'b0;
    bus.blue_button = 1'b0;
    cyc(Hold);
  endtask

  task automatic note(input logic r, input logic b, input logic [2:0] off);
    bus.note_R_judge = r;
    bus.note_B_judge = b;
    bus.offset       = off;
    cyc(2);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_score"}, 32'(bus.score), 32'(m_score));
    chk({tag, "_combo"}, 32'(bus.combo), 32'(m_combo));
    chk({tag, "_max"}, 32'(bus.max_combo), 32'(m_max));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.judge_vld && sb.size() != 0) begin
        e = sb.pop_front();
        chk("judge", 32'(bus.judge), 32'(e.j));
        chk("delete", 32'(bus.delete), 32'(e.del));
        chk("score", 32'(bus.score), 32'(e.sc));
        chk("combo", 32'(bus.combo), 32'(e.co));
        chk("max_combo", 32'(bus.max_combo), 32'(e.mx));
      end else if (bus.judge_vld || bus.delete) begin
        chk("stray_strobe", {30'd0, bus.judge_vld, bus.delete}, 32'd0);
      end
    end
  end

  initial begin
    bus.start        = 1'b0;
    bus.finish       = 1'b0;
    bus.red_button   = 1'b0;
    bus.blue_button  = 1'b0;
    bus.note_R_judge = 1'b0;
    bus.note_B_judge = 1'b0;
    bus.offset       = 3'd0;
    rst              = 1'b1;

    // 1: reset state, then start
    cyc(3);
    chk("rst_judge_vld", 32'(bus.judge_vld), 32'd0);
    chk("rst_delete", 32'(bus.delete), 32'd0);
    chk("rst_judge", 32'(bus.judge), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    check_counters("rst");
    rst = 1'b0;
    cyc(1);
    pulse_start();
    chk("start_done", 32'(bus.done), 32'd0);

    // 2: red PERFECT at offset 3, then fall of a consumed note is silent
    note(1'b1, 1'b0, 3'd3);
    push_hit(3'd3);
    press(1'b1, 1'b0);
    note(1'b0, 1'b0, 3'd3);
    cyc(3);
    check_counters("red_perfect");

    // 3: blue GOOD at offset 6
    note(1'b0, 1'b1, 3'd6);
    push_hit(3'd6);
    press(1'b0, 1'b1);
    note(1'b0, 1'b0, 3'd6);
    cyc(3);
    check_counters("blue_good");

    // Build combo to 5 across PERFECT window edges and just outside it
    note(1'b1, 1'b0, 3'd2); push_hit(3'd2); press(1'b1, 1'b0); note(1'b0, 1'b0, 3'd2);
    note(1'b0, 1'b1, 3'd4); push_hit(3'd4); press(1'b0, 1'b1); note(1'b0, 1'b0, 3'd4);
    note(1'b1, 1'b0, 3'd5); push_hit(3'd5); press(1'b1, 1'b0); note(1'b0, 1'b0, 3'd5);
    cyc(3);
    check_counters("combo5");

    // 4: unpressed note scrolls past
    note(1'b1, 1'b0, 3'd1);
    cyc(5);
    push_miss();
    note(1'b0, 1'b0, 3'd1);
    cyc(3);
    check_counters("scroll_miss");

    // 5: wrong colour misses; a later correct press on the same note is ignored
    note(1'b0, 1'b1, 3'd3);
    push_miss();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    note(1'b0, 1'b0, 3'd3);
    cyc(3);
    check_counters("wrong_colour");

    // Both buttons together on a note, then a press with no note
    note(1'b1, 1'b0, 3'd3);
    push_miss();
    press(1'b1, 1'b1);
    note(1'b0, 1'b0, 3'd3);
    press(1'b1, 1'b0);
    cyc(3);
    check_counters("both_and_empty");

    // 6: bouncy red button yields exactly one press
    note(1'b1, 1'b0, 3'd3);
    push_hit(3'd3);
    for (int k = 0; k < 20; k++) begin
      bus.red_button = ~bus.red_button;
      cyc(100);
    end
    press(1'b1, 1'b0);
    note(1'b0, 1'b0, 3'd3);
    cyc(3);
    check_counters("bounce");

    // finish freezes judging
    bus.finish = 1'b1;
    cyc(1);
    bus.finish = 1'b0;
    chk("finish_done", 32'(bus.done), 32'd1);
    note(1'b1, 1'b0, 3'd3);
    press(1'b1, 1'b0);
    note(1'b0, 1'b0, 3'd3);
    cyc(3);
    check_counters("frozen");
    chk("frozen_done", 32'(bus.done), 32'd1);

    // start from DONE clears and returns to IDLE; next start plays
    pulse_start();
    model_clear();
    chk("rearm_done", 32'(bus.done), 32'd0);
    check_counters("rearm");
    pulse_start();
    note(1'b1, 1'b0, 3'd2);
    push_hit(3'd2);
    press(1'b1, 1'b0);
    note(1'b0, 1'b0, 3'd2);
    cyc(3);
    check_counters("replay");

    // start during PLAY restarts and stays in PLAY
    pulse_start();
    model_clear();
    check_counters("restart");
    note(1'b0, 1'b1, 3'd0);
    push_hit(3'd0);
    press(1'b0, 1'b1);
    note(1'b0, 1'b0, 3'd0);
    cyc(3);
    check_counters("after_restart");

    cyc(10);
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
